// File: rtl/glb_access_ctrl.sv
// Command sequencer for the iact/psum/weight global buffers: streams words into a
// selected GLB, or reads a contiguous block out through a two-entry output FIFO.
module glb_access_ctrl #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [1:0]               sel,
    input  logic [ADDR_BITWIDTH-1:0] base_addr,
    input  logic [ADDR_BITWIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               glb_read_req,
    output logic [2:0]               glb_write_en,
    output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
    output logic [ADDR_BITWIDTH-1:0] glb_w_addr,
    output logic [DATA_BITWIDTH-1:0] glb_w_data,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data_iact,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data_psum,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data_wght
);
    localparam int CW = ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               sel_q;
    logic [ADDR_BITWIDTH-1:0] base_q;
    logic [CW-1:0]            len_q, issue_cnt, retire_cnt;
    logic                     err_q;
    logic                     wr_pend;
    logic [ADDR_BITWIDTH-1:0] wr_addr;
    logic [DATA_BITWIDTH-1:0] wr_data;
    logic                     rd_pend;
    logic [DATA_BITWIDTH-1:0] fifo_mem [2];
    logic                     fifo_rd_ptr, fifo_wr_ptr;
    logic [1:0]               fifo_cnt;
    logic [DATA_BITWIDTH-1:0] rd_data_sel;
    logic [2:0]               sel_oh;
    logic                     accept, wr_hs, rd_issue, push, pop;

    assign sel_oh    = 3'b001 << sel_q;
    assign accept    = (state == IDLE) && start && (sel != 2'd3);
    assign in_ready  = (state == WRITE) && (issue_cnt < len_q);
    assign wr_hs     = in_valid && in_ready;
    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = rd_pend;
    // A pop in the same cycle frees a slot, which keeps reads at one word per cycle.
    assign rd_issue  = (state == READ) && (issue_cnt < len_q) &&
                       ((3'(fifo_cnt) + 3'(rd_pend)) < (3'd2 + 3'(pop)));

    assign glb_read_req = rd_issue ? sel_oh : 3'b000;
    assign glb_write_en = wr_pend ? sel_oh : 3'b000;
    assign glb_r_addr   = base_q + issue_cnt[ADDR_BITWIDTH-1:0];
    assign glb_w_addr   = wr_addr;
    assign glb_w_data   = wr_data;
    assign out_data     = out_valid ? fifo_mem[fifo_rd_ptr] : '0;
    assign busy         = (state == WRITE) || (state == READ);
    assign done         = (state == DONE);
    assign err          = err_q;

    always_comb begin
        rd_data_sel = glb_r_data_iact;
        case (sel_q)
            2'd1:    rd_data_sel = glb_r_data_psum;
            2'd2:    rd_data_sel = glb_r_data_wght;
            default: rd_data_sel = glb_r_data_iact;
        endcase
    end

    // Zero-length commands pass through WRITE/READ for one cycle so done lands at t+2.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = mode ? READ : WRITE;
            WRITE: if (issue_cnt == len_q && (wr_pend || len_q == '0)) state_nxt = DONE;
            READ:  if (len_q == '0 || (pop && retire_cnt + CW'(1) == len_q)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel_q       <= '0;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            retire_cnt  <= '0;
            err_q       <= 1'b0;
            wr_pend     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_pend     <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_cnt    <= '0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            state   <= state_nxt;
            err_q   <= (state == IDLE) && start && (sel == 2'd3);
            wr_pend <= wr_hs;
            rd_pend <= rd_issue;
            if (accept) begin
                sel_q      <= sel;
                base_q     <= base_addr;
                len_q      <= length;
                issue_cnt  <= '0;
                retire_cnt <= '0;
            end
            if (wr_hs) begin
                wr_addr   <= base_q + issue_cnt[ADDR_BITWIDTH-1:0];
                wr_data   <= in_data;
                issue_cnt <= issue_cnt + CW'(1);
            end
            if (rd_issue) issue_cnt <= issue_cnt + CW'(1);
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= rd_data_sel;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
                retire_cnt  <= retire_cnt + CW'(1);
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end
endmodule
